// File: rtl/shift_seq_pkg.sv
// Shared types and width helpers for the shift_seq_ctrl serializer.
package shift_seq_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } shift_seq_state_e;

   // Divider counter width; a divide-by-1 still keeps a 1-bit counter.
   function automatic int SHIFT_SEQ_DIV_W(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/shift_register.sv
// Parallel-load shift register with MSB-first shift-out, driven by shift_seq_ctrl.
module shift_register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   always_ff @(posedge clk) begin
      if (reset)
         data_out <= '0;
      else if (load)
         data_out <= data_in;
      else if (shift)
         data_out <= {data_out[WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/shift_seq_tick.sv
// Bit-period divider: tick marks the last of DIV cycles of each serial bit.
module shift_seq_tick
   import shift_seq_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int               DIV_W = SHIFT_SEQ_DIV_W(DIV);
   localparam logic [DIV_W-1:0] LAST  = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences an external shift_register to serialize words MSB-first, DIV cycles per bit.
// Define SHIFT_SEQ_BACK2BACK_EN to accept the next word on the done cycle (gapless output).
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             sr_load,
   output logic             sr_shift,
   output logic [WIDTH-1:0] sr_data,
   input  logic             sr_msb,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int               BIT_W    = $clog2(WIDTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   shift_seq_state_e state;
   logic [BIT_W-1:0] bit_cnt;
   logic             tick;
   logic             active;
   logic             last_bit;
   logic             accept;

   // Gating with reset keeps every output low while reset is held, even mid-word.
   assign active   = (state == ACTIVE) && !reset;
   assign last_bit = (bit_cnt == LAST_BIT);
   assign done     = active && tick && last_bit;
   assign sr_shift = active && tick && !last_bit;

`ifdef SHIFT_SEQ_BACK2BACK_EN
   assign in_ready = !reset && ((state == IDLE) || done);
`else
   assign in_ready = !reset && (state == IDLE);
`endif

   assign accept    = in_valid && in_ready;
   assign sr_load   = accept;
   assign sr_data   = accept ? in_data : '0;
   assign busy      = active;
   assign ser_valid = active;
   assign ser_out   = active && sr_msb;

   shift_seq_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (accept || (state == IDLE)),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= ACTIVE;
                  bit_cnt <= '0;
               end
            end
            ACTIVE: begin
               // An accept here only happens on the done cycle of a back-to-back run.
               if (accept)
                  bit_cnt <= '0;
               else if (tick) begin
                  if (last_bit)
                     state <= IDLE;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
